zest_spi_arbiter: RTL

//  Shares one SPI master between two requesters on the Zest digitizer housekeeping SPI bus (U15/U18).

---
 rtl/zest_spi_arbiter_if.sv | 31 +++
 rtl/zest_spi_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/zest_spi_arbiter_if.sv
// Bundle of requester-side and SPI-master-side signals for zest_spi_arbiter.
// master: the arbiter's view; slave: the surrounding requesters and SPI master.
interface zest_spi_arbiter_if #(
  parameter int DW = 24
);
  logic          req0;
  logic [DW-1:0] wdata0;
  logic          ack0;
  logic          req1;
  logic [DW-1:0] wdata1;
  logic          ack1;
  logic [DW-1:0] rdata;
  logic          err;
  logic          owner;
  logic          busy;
  logic          spi_start;
  logic [DW-1:0] spi_wdata;
  logic          spi_busy;
  logic          spi_done;
  logic [DW-1:0] spi_rdata;

  modport master (
    input  req0, wdata0, req1, wdata1, spi_busy, spi_done, spi_rdata,
    output ack0, ack1, rdata, err, owner, busy, spi_start, spi_wdata
  );

  modport slave (
    output req0, wdata0, req1, wdata1, spi_busy, spi_done, spi_rdata,
    input  ack0, ack1, rdata, err, owner, busy, spi_start, spi_wdata
  );
endinterface

// File: rtl/zest_spi_arbiter.sv
// Round-robin arbiter sharing one SPI master between the local-bus host (port 0)
// and the monitor poller (port 1). Optional WAIT timeout: define ZEST_SPI_ARB_TIMEOUT_EN.
module zest_spi_arbiter #(
  parameter int DW          = 24,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst,
  zest_spi_arbiter_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t        state;
  logic          owner_q;
  logic          busy_q;
  logic          spi_start_q;
  logic [DW-1:0] spi_wdata_q;
  logic          ack0_q;
  logic          ack1_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;
  logic          win;
  logic          to_hit;

  // With both ports requesting, the port that did not win last time gets it.
  assign win = (bus.req0 & bus.req1) ? ~owner_q : bus.req1;

`ifdef ZEST_SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst)                  wait_cnt <= '0;
    else if (state == S_START) wait_cnt <= '0;
    else if (state == S_WAIT)  wait_cnt <= wait_cnt + CW'(1);
  end

  assign to_hit = (wait_cnt == CW'(TIMEOUT_CYC - 1));
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;

  assign to_hit = 1'b0;
`endif

  // The SPI master's busy is status only; sequencing relies on spi_done.
  logic unused_spi_busy;
  assign unused_spi_busy = bus.spi_busy;

  always_ff @(posedge clk) begin
    // NOTE: every register in a clocked block uses <= so all of them see the
    // pre-edge values of each other, regardless of statement order.
    if (rst) begin
      state       <= S_IDLE;
      owner_q     <= 1'b1;
      busy_q      <= 1'b0;
      spi_start_q <= 1'b0;
      spi_wdata_q <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low each cycle; only the state that owns a
      // pulse raises it, so nothing has to remember to clear it later.
      spi_start_q <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req0 | bus.req1) begin
            state       <= S_START;
            owner_q     <= win;
            spi_wdata_q <= win ? bus.wdata1 : bus.wdata0;
            spi_start_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          // spi_done is checked first so it wins over a same-cycle timeout.
          if (bus.spi_done | to_hit) begin
            state  <= S_DONE;
            ack0_q <= ~owner_q;
            ack1_q <= owner_q;
            if (bus.spi_done) begin
              rdata_q <= bus.spi_rdata;
              err_q   <= 1'b0;
            end else begin
              rdata_q <= '1;
              err_q   <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.owner     = owner_q;
  assign bus.busy      = busy_q;
  assign bus.spi_start = spi_start_q;
  assign bus.spi_wdata = spi_wdata_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;

endmodule
